// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and width helpers for the PLL reset sequencer
//
// Contents:
//   state_e     sequencer state, fixed encodings visible on the debug port
//   STATE_W     width of the state encoding
//   RETRY_W     width of the retry counter
//   LOSS_W      width of the lock-loss counter (saturating)
//   cnt_w()     counter width for a given maximum count, never below 1
//   max2()      larger of two ints
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 3;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer, async active-high reset to 0
//
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset, clears both flops
//   d    in   asynchronous input
//   q    out  synchronized output, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL bring-up, lock supervision and system reset release
//
// Runs entirely on refclk so it never depends on the clocks it supervises.
//
// Ports:
//   refclk      in   free-running reference clock (sole clock)
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock, asynchronous to refclk
//   pll_rst     out  PLL reset, high in PLL_RST and FAIL
//   sys_rst     out  system reset, high unless in RUN
//   ready       out  high only in RUN
//   fail        out  high only in FAIL (terminal until rst)
//   retry_cnt   out  lock timeouts in the current bring-up
//   loss_cnt    out  lock-loss events seen in RUN, saturating
//   state       out  current state encoding, debug only
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt,
  output logic [STATE_W-1:0] state
);

  localparam int PH_W  = cnt_w(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES));
  localparam int TMO_W = cnt_w(LOCK_TIMEOUT_CYCLES);

  localparam logic [PH_W-1:0]    PH_RST_LAST = PH_W'(PLL_RST_CYCLES - 1);
  localparam logic [PH_W-1:0]    PH_STB_LAST = PH_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_SAT    = '1;

  logic locked_s;

  state_e             state_d, state_q;
  logic [PH_W-1:0]    phase_d, phase_q;
  logic [TMO_W-1:0]   tmo_d, tmo_q;
  logic [RETRY_W-1:0] retry_d, retry_q;
  logic [LOSS_W-1:0]  loss_d, loss_q;
  logic               pll_rst_d, pll_rst_q;
  logic               sys_rst_d, sys_rst_q;
  logic               ready_d, ready_q;
  logic               fail_d, fail_q;
  logic               timeout;
  logic               do_timeout;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // State and counter register; outputs are registered alongside so they
  // change on the same edge as state and cannot glitch.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      phase_q   <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    do_timeout = 1'b0;
    timeout    = (tmo_q == TMO_LAST);

    unique case (state_q)
      ST_PLL_RST: begin
        if (phase_q == PH_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          phase_d = '0;
          tmo_d   = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout) begin
          do_timeout = 1'b1;
        end else if (locked_s) begin
          state_d = ST_STABLE;
          phase_d = '0;
        end
      end

      ST_STABLE: begin
        // tmo_cnt keeps running across STABLE/WAIT_LOCK bounces so a
        // chattering lock cannot hold off the timeout. The timeout also wins
        // over a lock drop so tmo_cnt never passes its last value.
        tmo_d = tmo_q + TMO_W'(1);
        if (locked_s && (phase_q == PH_STB_LAST)) begin
          state_d = ST_RUN;
        end else if (timeout) begin
          do_timeout = 1'b1;
        end else if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          if (loss_q != LOSS_SAT) begin
            loss_d = loss_q + LOSS_W'(1);
          end
          retry_d = '0;
          state_d = ST_PLL_RST;
          phase_d = '0;
        end
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        state_d = ST_PLL_RST;
        phase_d = '0;
      end
    endcase

    if (do_timeout) begin
      tmo_d = '0;
      if (retry_q == RETRY_MAX) begin
        state_d = ST_FAIL;
      end else begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_PLL_RST;
        phase_d = '0;
      end
    end
  end

  // Output decode from the next state, registered above.
  always_comb begin
    pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int PR = 4;
  localparam int LS = 8;
  localparam int TO = 64;
  localparam int MR = 2;

  localparam int M_PLL_RST = 0;
  localparam int M_WAIT    = 1;
  localparam int M_STABLE  = 2;
  localparam int M_RUN     = 3;
  localparam int M_FAIL    = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (PR),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .state      (state)
  );

  typedef struct {
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [2:0] retry;
    logic [7:0] loss;
    logic [2:0] state;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lock history as a queue, attempt age and stable run
  // length as plain integers.
  int m_mode, m_elapsed, m_age, m_run, m_retries, m_losses;
  bit m_hist[$];

  logic last_pll_rst, last_sys_rst, last_ready;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit raw);
    bit   ls;
    bit   tmo;
    exp_t e;
    if (r) begin
      m_mode = M_PLL_RST; m_elapsed = 0; m_age = 0; m_run = 0;
      m_retries = 0; m_losses = 0;
      m_hist.delete();
    end else begin
      ls = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 1'b0;
      m_hist.push_back(raw);
      if (m_hist.size() > 2) void'(m_hist.pop_front());
      tmo = 1'b0;
      case (m_mode)
        M_PLL_RST: begin
          m_elapsed++;
          if (m_elapsed == PR) begin m_mode = M_WAIT; m_age = 0; end
        end
        M_WAIT: begin
          m_age++;
          if (m_age == TO) tmo = 1'b1;
          else if (ls) begin m_mode = M_STABLE; m_run = 0; end
        end
        M_STABLE: begin
          m_age++;
          if (ls && (m_run + 1 == LS)) m_mode = M_RUN;
          else if (m_age == TO) tmo = 1'b1;
          else if (!ls) m_mode = M_WAIT;
          else m_run++;
        end
        M_RUN: begin
          if (!ls) begin
            m_losses  = (m_losses < 255) ? m_losses + 1 : 255;
            m_retries = 0;
            m_mode    = M_PLL_RST;
            m_elapsed = 0;
          end
        end
        default: ;
      endcase
      if (tmo) begin
        if (m_retries == MR) m_mode = M_FAIL;
        else begin m_retries++; m_mode = M_PLL_RST; m_elapsed = 0; end
      end
    end
    e.pll_rst = (m_mode == M_PLL_RST) || (m_mode == M_FAIL);
    e.sys_rst = (m_mode != M_RUN);
    e.ready   = (m_mode == M_RUN);
    e.fail    = (m_mode == M_FAIL);
    e.retry   = 3'(m_retries);
    e.loss    = 8'(m_losses);
    e.state   = 3'(m_mode);
    sb_q.push_back(e);
  endtask

  // One cycle: sample DUT mid-cycle, drive inputs, predict the next edge.
  task automatic cyc(input bit r, input bit l);
    @(negedge refclk);
    last_pll_rst = pll_rst;
    last_sys_rst = sys_rst;
    last_ready   = ready;
    rst        = r;
    pll_locked = l;
    model_step(r, l);
  endtask

  // Monitor: compare every registered output after each edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge refclk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (pll_rst !== e.pll_rst || sys_rst !== e.sys_rst || ready !== e.ready ||
            fail !== e.fail || retry_cnt !== e.retry || loss_cnt !== e.loss ||
            state !== e.state) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got st=%0d pr=%0b sr=%0b rdy=%0b f=%0b rc=%0d lc=%0d exp st=%0d pr=%0b sr=%0b rdy=%0b f=%0b rc=%0d lc=%0d",
                   $time, state, pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt,
                   e.state, e.pll_rst, e.sys_rst, e.ready, e.fail, e.retry, e.loss);
        end
      end
    end
  end

  int  guard;
  int  n_edges;
  int  n_high;
  int  runs[$];
  bit  samp[$];
  bit  lv;
  int  len;

  initial begin : stim
    // Scenario 1: locked from the start.
    repeat (3) cyc(1'b1, 1'b1);
    repeat (30) cyc(1'b0, 1'b1);
    chk("s1_ready", int'(ready), 1);
    chk("s1_retry", int'(retry_cnt), 0);

    // Lock rises right after WAIT_LOCK entry: 2 sync edges + 1 + LS.
    repeat (2) cyc(1'b1, 1'b0);
    guard = 0;
    while (m_mode != M_WAIT && guard < 20) begin cyc(1'b0, 1'b0); guard++; end
    cyc(1'b0, 1'b1);
    n_edges = 0;
    guard = 0;
    do begin
      cyc(1'b0, 1'b1);
      n_edges++;
      guard++;
    end while (last_sys_rst !== 1'b0 && guard < 40);
    chk("s1_sysrst_latency", n_edges, 2 + 1 + LS);

    // Scenario 2: never locks -> three pulses then FAIL.
    repeat (2) cyc(1'b1, 1'b0);
    samp.delete();
    repeat (260) begin
      cyc(1'b0, 1'b0);
      samp.push_back(last_pll_rst);
    end
    runs.delete();
    len = 1;
    for (int i = 1; i < samp.size(); i++) begin
      if (samp[i] == samp[i-1]) len++;
      else begin runs.push_back(len); len = 1; end
    end
    runs.push_back(len);
    for (int k = 0; k < 6; k++)
      chk("s2_pll_rst_run", (runs.size() > k) ? runs[k] : -1, (k % 2 == 1) ? TO : PR);
    chk("s2_final_high", int'(samp[samp.size()-1]), 1);
    chk("s2_fail", int'(fail), 1);
    chk("s2_state", int'(state), M_FAIL);
    chk("s2_sys_rst", int'(sys_rst), 1);

    // Scenario 3: chattering lock never reaches RUN.
    repeat (2) cyc(1'b1, 1'b0);
    n_high = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, (i % 6) != 5);
      if (last_ready === 1'b1) n_high++;
    end
    chk("s3_never_ready", n_high, 0);
    chk("s3_retry", int'(retry_cnt), 1);

    // Scenario 4: lock loss in RUN.
    repeat (2) cyc(1'b1, 1'b1);
    guard = 0;
    while (m_mode != M_RUN && guard < 100) begin cyc(1'b0, 1'b1); guard++; end
    repeat (5) cyc(1'b0, 1'b1);
    chk("s4_ready", int'(last_ready), 1);
    n_edges = -1;
    n_high = 0;
    for (int i = 0; i < 33; i++) begin
      cyc(1'b0, (i < 3) ? 1'b0 : 1'b1);
      if (n_edges < 0 && last_sys_rst === 1'b1) n_edges = i;
      if (last_pll_rst === 1'b1) n_high++;
    end
    chk("s4_sysrst_edges", n_edges, 2 + 1);
    chk("s4_pll_rst_width", n_high, PR);
    chk("s4_loss", int'(loss_cnt), 1);
    chk("s4_retry", int'(retry_cnt), 0);

    // Scenario 5: 300 losses saturate loss_cnt.
    for (int n = 0; n < 300; n++) begin
      guard = 0;
      while (m_mode != M_RUN && guard < 60) begin cyc(1'b0, 1'b1); guard++; end
      repeat (3) cyc(1'b0, 1'b0);
    end
    guard = 0;
    while (m_mode != M_RUN && guard < 60) begin cyc(1'b0, 1'b1); guard++; end
    cyc(1'b0, 1'b1);
    #1;
    chk("s5_loss_sat", int'(loss_cnt), 255);

    // Scenario 6: rst mid-STABLE and mid-FAIL acts at once.
    repeat (3) cyc(1'b0, 1'b0);
    guard = 0;
    while (m_mode != M_STABLE && guard < 60) begin cyc(1'b0, 1'b1); guard++; end
    repeat (3) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    #1;
    chk("s6a_state", int'(state), M_PLL_RST);
    chk("s6a_loss", int'(loss_cnt), 0);
    chk("s6a_pll_rst", int'(pll_rst), 1);
    chk("s6a_sys_rst", int'(sys_rst), 1);
    guard = 0;
    while (m_mode != M_FAIL && guard < 400) begin cyc(1'b0, 1'b0); guard++; end
    repeat (5) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    #1;
    chk("s6b_state", int'(state), M_PLL_RST);
    chk("s6b_fail", int'(fail), 0);
    chk("s6b_retry", int'(retry_cnt), 0);

    // Random lock behaviour with occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      lv  = ($urandom_range(0, 3) != 0);
      len = lv ? $urandom_range(1, 30) : $urandom_range(1, 5);
      if ($urandom_range(0, 19) == 0) cyc(1'b1, lv);
      for (int k = 0; k < len; k++) cyc(1'b0, lv);
    end

    repeat (3) @(posedge refclk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
